// File: rtl/rank_filter_3x3.sv
// rank_filter_3x3: four-stage pipelined 3x3 rank filter over streamed pixel columns.
// Define RANK_MODE_EN to add the min/max modes selected by 'mode'; otherwise the filter is median only.
module rank_filter_3x3 #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              sol,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  input  logic [DATA_W-1:0] din2,
  input  logic [1:0]        mode,
  output logic              valid_out,
  output logic [DATA_W-1:0] dout
);

  typedef logic [DATA_W-1:0] pix_t;

  function automatic pix_t min2(input pix_t a, input pix_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic pix_t max2(input pix_t a, input pix_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
    return min2(min2(a, b), c);
  endfunction

  function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
    return max2(max2(a, b), c);
  endfunction

  function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  logic [CNT_W-1:0] col_cnt;
  logic [CNT_W-1:0] col_idx;

  logic             s1_valid;
  logic [CNT_W-1:0] s1_idx;
  pix_t             s1_lo, s1_md, s1_hi;

  logic             w_valid;
  logic [2:0][DATA_W-1:0] w_lo, w_md, w_hi;

  logic             s3_valid;
  pix_t             s3_lo, s3_md, s3_hi;

`ifdef RANK_MODE_EN
  logic [1:0]       s1_mode, w_mode, s3_mode;
  pix_t             s3_gmin, s3_gmax;
`else
  logic [1:0]       unused_mode;
  assign unused_mode = mode;
`endif

  // col_cnt holds the index the next accepted column will take unless sol restarts the row
  assign col_idx = sol ? '0 : col_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt <= '0;
    end else if (valid_in) begin
      col_cnt <= (col_idx == CNT_W'(IMG_W - 1)) ? '0 : col_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_lo    <= '0;
      s1_md    <= '0;
      s1_hi    <= '0;
`ifdef RANK_MODE_EN
      s1_mode  <= '0;
`endif
    end else begin
      s1_valid <= valid_in;
      if (valid_in) begin
        s1_idx  <= col_idx;
        s1_lo   <= min3(din0, din1, din2);
        s1_md   <= med3(din0, din1, din2);
        s1_hi   <= max3(din0, din1, din2);
`ifdef RANK_MODE_EN
        s1_mode <= mode;
`endif
      end
    end
  end

  // The window only moves on real columns, so gaps in valid_in leave it intact
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_valid <= 1'b0;
      w_lo    <= '0;
      w_md    <= '0;
      w_hi    <= '0;
`ifdef RANK_MODE_EN
      w_mode  <= '0;
`endif
    end else begin
      w_valid <= s1_valid && (s1_idx >= CNT_W'(2));
      if (s1_valid) begin
        w_lo   <= {w_lo[1:0], s1_lo};
        w_md   <= {w_md[1:0], s1_md};
        w_hi   <= {w_hi[1:0], s1_hi};
`ifdef RANK_MODE_EN
        w_mode <= s1_mode;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_valid <= 1'b0;
      s3_lo    <= '0;
      s3_md    <= '0;
      s3_hi    <= '0;
`ifdef RANK_MODE_EN
      s3_gmin  <= '0;
      s3_gmax  <= '0;
      s3_mode  <= '0;
`endif
    end else begin
      s3_valid <= w_valid;
      s3_lo    <= max3(w_lo[0], w_lo[1], w_lo[2]);
      s3_md    <= med3(w_md[0], w_md[1], w_md[2]);
      s3_hi    <= min3(w_hi[0], w_hi[1], w_hi[2]);
`ifdef RANK_MODE_EN
      s3_gmin  <= min3(w_lo[0], w_lo[1], w_lo[2]);
      s3_gmax  <= max3(w_hi[0], w_hi[1], w_hi[2]);
      s3_mode  <= w_mode;
`endif
    end
  end

  // dout only updates on a valid result and otherwise holds the last one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      dout      <= '0;
    end else begin
      valid_out <= s3_valid;
      if (s3_valid) begin
`ifdef RANK_MODE_EN
        case (s3_mode)
          2'b01:   dout <= s3_gmin;
          2'b10:   dout <= s3_gmax;
          default: dout <= med3(s3_lo, s3_md, s3_hi);
        endcase
`else
        dout <= med3(s3_lo, s3_md, s3_hi);
`endif
      end
    end
  end

endmodule

// File: tb/tb_rank_filter_3x3.sv
// tb_rank_filter_3x3: randomized and directed checks of rank_filter_3x3 against a sort-the-nine-pixels model.
// Follows the RANK_MODE_EN build of the design for min/max expectations.
module tb_rank_filter_3x3;

  localparam int DATA_W = 8;
  localparam int IMG_W  = 8;
  localparam int CNT_W  = 3;
`ifdef RANK_MODE_EN
  localparam bit MODE_EN = 1'b1;
`else
  localparam bit MODE_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_in;
  logic              sol;
  logic [DATA_W-1:0] din0, din1, din2;
  logic [1:0]        mode;
  logic              valid_out;
  logic [DATA_W-1:0] dout;

  typedef struct {
    int         due;
    logic [7:0] val;
  } exp_t;

  exp_t       expq[$];
  logic [23:0] hist[$];
  logic [7:0] got[$];
  int         model_cnt;
  int         cyc;
  int         vectors;
  int         miscompares;
  logic       exp_v;
  logic [7:0] exp_d;
  logic [7:0] last_dout;

  rank_filter_3x3 #(.DATA_W(DATA_W), .IMG_W(IMG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .sol(sol),
    .din0(din0), .din1(din1), .din2(din2), .mode(mode),
    .valid_out(valid_out), .dout(dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: gather the nine window pixels, sort them, pick by rank.
  function automatic logic [7:0] rank_ref(input logic [1:0] m);
    int px[9];
    int t;
    logic [7:0] r;
    for (int k = 0; k < 9; k++) px[k] = int'((hist[k / 3] >> (8 * (k % 3))) & 24'hFF);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8 - i; j++)
        if (px[j] > px[j + 1]) begin t = px[j]; px[j] = px[j + 1]; px[j + 1] = t; end
    r = 8'(px[4]);
    if (MODE_EN && m == 2'b01) r = 8'(px[0]);
    if (MODE_EN && m == 2'b10) r = 8'(px[8]);
    return r;
  endfunction

  // Drives one cycle of inputs and records what the model expects from it.
  task automatic step(input bit v, input bit s, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [1:0] m);
    int idx;
    valid_in = v; sol = s; din0 = a; din1 = b; din2 = c; mode = m;
    if (v) begin
      idx = s ? 0 : model_cnt;
      model_cnt = (idx == IMG_W - 1) ? 0 : idx + 1;
      hist.push_back({a, b, c});
      if (hist.size() > 3) hist.delete(0);
      if (idx >= 2) expq.push_back('{due: cyc + 4, val: rank_ref(m)});
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    #1;
    vectors++;
    if ({valid_out, dout} !== 9'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_state got valid_out=%b dout=%0d, want 0/0", valid_out, dout);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    model_cnt = 0; last_dout = 8'd0;
  endtask

  // Ramp rows: din0=c, din1=c+10, din2=c+20; idle cycles in gaps carry a stray sol.
  task automatic test_ramp(input logic [1:0] m, input int gap, input string name);
    int base;
    got.delete();
    for (int c = 0; c < IMG_W + 6; c++) begin
      for (int g = 0; g <= ((c < IMG_W) ? gap : 0); g++) begin
        @(negedge clk);
        exp_v = 1'b0;
        if (expq.size() != 0) exp_v = (expq[0].due == cyc);
        exp_d = exp_v ? expq[0].val : last_dout;
        vectors++;
        if ({valid_out, dout} !== {exp_v, exp_d}) begin
          miscompares++;
          $display("[TB] FAIL %s cyc=%0d got valid_out=%b dout=%0d, want valid_out=%b dout=%0d",
                   name, cyc, valid_out, dout, exp_v, exp_d);
        end
        if (exp_v) begin expq.delete(0); last_dout = exp_d; got.push_back(dout); end
        if (c < IMG_W && g == gap) step(1, c == 0, 8'(c), 8'(c + 10), 8'(c + 20), m);
        else step(0, 1, 8'd99, 8'd99, 8'd99, m);
      end
    end
    base = (MODE_EN && m == 2'b01) ? 0 : (MODE_EN && m == 2'b10) ? 22 : 11;
    vectors++;
    if (got.size() != 6) begin
      miscompares++;
      $display("[TB] FAIL %s_count got %0d outputs, want 6", name, got.size());
    end
    for (int k = 0; k < got.size(); k++) begin
      vectors++;
      if (got[k] !== 8'(base + k)) begin
        miscompares++;
        $display("[TB] FAIL %s_value[%0d] got %0d, want %0d", name, k, got[k], base + k);
      end
    end
  endtask

  task automatic test_spike;
    got.delete();
    for (int c = 0; c < IMG_W + 6; c++) begin
      @(negedge clk);
      exp_v = 1'b0;
      if (expq.size() != 0) exp_v = (expq[0].due == cyc);
      exp_d = exp_v ? expq[0].val : last_dout;
      vectors++;
      if ({valid_out, dout} !== {exp_v, exp_d}) begin
        miscompares++;
        $display("[TB] FAIL spike cyc=%0d got valid_out=%b dout=%0d, want valid_out=%b dout=%0d",
                 cyc, valid_out, dout, exp_v, exp_d);
      end
      if (exp_v) begin expq.delete(0); last_dout = exp_d; got.push_back(dout); end
      if (c < IMG_W) step(1, c == 0, 8'd50, (c == 3) ? 8'd255 : 8'd50, 8'd50, 2'b00);
      else step(0, 0, 0, 0, 0, 0);
    end
    for (int k = 0; k < got.size(); k++) begin
      vectors++;
      if (got[k] !== 8'd50) begin
        miscompares++;
        $display("[TB] FAIL spike_value[%0d] got %0d, want 50", k, got[k]);
      end
    end
  endtask

  // Row restarted by sol on its 5th column, followed by five more columns.
  task automatic test_sol_restart;
    got.delete();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      exp_v = 1'b0;
      if (expq.size() != 0) exp_v = (expq[0].due == cyc);
      exp_d = exp_v ? expq[0].val : last_dout;
      vectors++;
      if ({valid_out, dout} !== {exp_v, exp_d}) begin
        miscompares++;
        $display("[TB] FAIL sol_restart cyc=%0d got valid_out=%b dout=%0d, want valid_out=%b dout=%0d",
                 cyc, valid_out, dout, exp_v, exp_d);
      end
      if (exp_v) begin expq.delete(0); last_dout = exp_d; got.push_back(dout); end
      if (c < 10) step(1, c == 0 || c == 4, 8'($urandom), 8'($urandom), 8'($urandom), 2'b00);
      else step(0, 0, 0, 0, 0, 0);
    end
    vectors++;
    if (got.size() != 6) begin
      miscompares++;
      $display("[TB] FAIL sol_restart_count got %0d outputs, want 6", got.size());
    end
  endtask

  task automatic test_random;
    logic [7:0] px[3];
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      exp_v = 1'b0;
      if (expq.size() != 0) exp_v = (expq[0].due == cyc);
      exp_d = exp_v ? expq[0].val : last_dout;
      vectors++;
      if ({valid_out, dout} !== {exp_v, exp_d}) begin
        miscompares++;
        $display("[TB] FAIL random cyc=%0d got valid_out=%b dout=%0d, want valid_out=%b dout=%0d",
                 cyc, valid_out, dout, exp_v, exp_d);
      end
      if (exp_v) begin expq.delete(0); last_dout = exp_d; end
      for (int k = 0; k < 3; k++)
        px[k] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      if (c < 390)
        step($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, px[0], px[1], px[2],
             2'($urandom_range(0, 3)));
      else step(0, 0, 0, 0, 0, 0);
    end
  endtask

  // Reset lands while a result is on the output and more are in flight.
  task automatic test_reset_mid;
    got.delete();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      exp_v = 1'b0;
      if (expq.size() != 0) exp_v = (expq[0].due == cyc);
      exp_d = exp_v ? expq[0].val : last_dout;
      vectors++;
      if ({valid_out, dout} !== {exp_v, exp_d}) begin
        miscompares++;
        $display("[TB] FAIL reset_mid_pre cyc=%0d got valid_out=%b dout=%0d, want valid_out=%b dout=%0d",
                 cyc, valid_out, dout, exp_v, exp_d);
      end
      if (exp_v) begin expq.delete(0); last_dout = exp_d; end
      if (c < 4) step(1, c == 0, 8'(c + 40), 8'(c + 60), 8'(c + 80), 2'b00);
      else step(0, 0, 0, 0, 0, 0);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({valid_out, dout} !== 9'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_async got valid_out=%b dout=%0d, want 0/0", valid_out, dout);
    end
    expq.delete(); hist.delete(); model_cnt = 0; last_dout = 8'd0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      exp_v = 1'b0;
      if (expq.size() != 0) exp_v = (expq[0].due == cyc);
      exp_d = exp_v ? expq[0].val : last_dout;
      vectors++;
      if ({valid_out, dout} !== {exp_v, exp_d}) begin
        miscompares++;
        $display("[TB] FAIL reset_mid_post cyc=%0d got valid_out=%b dout=%0d, want valid_out=%b dout=%0d",
                 cyc, valid_out, dout, exp_v, exp_d);
      end
      if (exp_v) begin expq.delete(0); last_dout = exp_d; got.push_back(dout); end
      if (c < 3) step(1, 0, 8'($urandom), 8'($urandom), 8'($urandom), 2'b00);
      else step(0, 0, 0, 0, 0, 0);
    end
    vectors++;
    if (got.size() != 1) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_count got %0d outputs, want 1", got.size());
    end
  endtask

  initial begin
    cyc = 0; vectors = 0; miscompares = 0;
    test_reset();
    test_ramp(2'b00, 0, "ramp_median");
    test_spike();
    test_ramp(2'b01, 0, "ramp_min");
    test_ramp(2'b10, 0, "ramp_max");
    test_ramp(2'b11, 0, "ramp_median11");
    test_ramp(2'b00, 1, "ramp_gaps");
    test_sol_restart();
    test_random();
    test_reset_mid();
    vectors++;
    if (expq.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain got %0d results never seen, want 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rank_filter_3x3.md
RANK_FILTER_3X3 -- requirements
Module: rank_filter_3x3

Interface
REQ-001 Parameter DATA_W, default 8: pixel width in bits.
REQ-002 Parameter IMG_W, default 640: pixels per image row.
REQ-003 Parameter CNT_W, default 10: column counter width; SHALL satisfy 2^CNT_W >= IMG_W.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 valid_in  input  1  din0/din1/din2 carry one window column this cycle.
REQ-007 sol  input  1  start of line; qualified by valid_in; marks column 0.
REQ-008 din0  input  DATA_W  pixel from the top row, current column.
REQ-009 din1  input  DATA_W  pixel from the middle row, current column.
REQ-010 din2  input  DATA_W  pixel from the bottom row, current column.
REQ-011 mode  input  2  rank select: 00 median, 01 min, 10 max, 11 median.
REQ-012 valid_out  output  1  dout holds a filtered pixel this cycle (one-cycle pulse per result).
REQ-013 dout  output  DATA_W  filtered pixel, centred on window column c-1.

Function
REQ-014 A pixel column SHALL be accepted on every rising edge where valid_in=1; there is no backpressure.
REQ-015 The column counter SHALL load 0 on acceptance with sol=1, else increment per acceptance, wrapping from IMG_W-1 to 0.
REQ-016 Stage 1 SHALL register the sorted (min, mid, max) of din0..din2 with the accepted column index and mode.
REQ-017 Stage 2 SHALL shift the sorted column into a 3-deep window only when stage 1 holds an accepted column.
REQ-018 Stage 3 SHALL register max-of-mins, median-of-mids, min-of-maxes, global min and global max of the window.
REQ-019 Stage 4 SHALL register dout: median-of-(stage-3 triple) for median mode; global min for 01; global max for 10.
REQ-020 A window SHALL be valid only when the completing column index >= 2; columns 0 and 1 of each row produce no output.
REQ-021 valid_out SHALL assert exactly 3 cycles after the valid_in edge of the completing column, for 1 cycle.
REQ-022 Gaps in valid_in SHALL NOT change result values; the pipeline stages carry per-stage valid flags and advance every cycle.
REQ-023 mode SHALL be sampled at the acceptance of the completing column; mid-row mode changes apply only to later windows.
REQ-024 dout SHALL hold its last value while valid_out=0.
REQ-025 Comparisons SHALL be unsigned; ties resolve to equal values, so any tied selection gives an identical result.
REQ-026 sol=1 with valid_in=0 SHALL be ignored.

Reset
REQ-027 rst=1 SHALL asynchronously clear valid_out, dout, the column counter, the window, and all stage registers and valid flags to 0.
REQ-028 Reset mid-row SHALL discard all partial windows; the first output after release requires three new columns.

Configuration
REQ-029 Macro RANK_MODE_EN defined: min/max modes are implemented per REQ-019.
REQ-030 RANK_MODE_EN undefined: mode is ignored, median only; min/max logic and the mode pipeline are absent.

Verification (DATA_W=8, IMG_W=8)
REQ-031 Assert rst mid-stream -> valid_out=0 and dout=0 immediately, without a clock edge.
REQ-032 Columns c=0..7 with sol at c=0, din0=c, din1=c+10, din2=c+20, mode=00 -> 6 outputs 11,12,13,14,15,16, each 3 cycles after columns 2..7.
REQ-033 All pixels 50 except din1=255 at c=3 -> every output is 50.
REQ-034 REQ-032 data with mode=01 -> outputs 0..5; mode=10 -> outputs 22..27; RANK_MODE_EN undefined -> 11..16 for both.
REQ-035 REQ-032 data with valid_in high every other cycle -> same 6 values, each valid_out 3 cycles after its completing column.
REQ-036 sol asserted at the 5th column of a row -> no output for that column or the next; outputs resume on the third column of the new row.
